csi2tx_ahb_arbiter: RTL and testbench



---
 rtl/csi2tx_ahb_pkg.sv | 28 ++
 rtl/csi2tx_ahb_burst_cnt.sv | 38 +++
 rtl/csi2tx_ahb_arbiter.sv | 70 +++++++
 tb/tb_csi2tx_ahb_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/csi2tx_ahb_pkg.sv
// csi2tx_ahb_pkg: shared AHB encodings, master IDs and arbiter state for the CSI-2 TX AHB subsystem
package csi2tx_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;
  localparam logic [3:0] MST1_ID       = 4'b0001;
  localparam logic [3:0] MST2_ID       = 4'b0010;
  typedef enum logic [1:0] {ARB, BURST, LOCKED} arb_state_e;
  // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    return (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4)  ? 4'd3 :
           (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8)  ? 4'd7 :
           (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 4'd15 : 4'd0;
  endfunction
endpackage

// File: rtl/csi2tx_ahb_burst_cnt.sv
// csi2tx_ahb_burst_cnt: beat counter for fixed-length AHB bursts
//   htrans_i/hburst_i/hready_i : muxed bus transfer type, burst type, ready
//   err_i                      : non-OKAY slave response, clears the count
//   load_en_i                  : arbiter is in ARB, a new burst may start
//   start_o                    : fixed-length burst accepted this edge
//   last_beat_o                : grant may move this edge (final beat follows)
//   early_term_o               : burst abandoned with IDLE/NONSEQ
module csi2tx_ahb_burst_cnt
  import csi2tx_ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  input  logic       hready_i,
  input  logic       err_i,
  input  logic       load_en_i,
  output logic       start_o,
  output logic       last_beat_o,
  output logic       early_term_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       seq_ok;
  always_comb begin
    seq_ok       = hready_i && htrans_i == HTRANS_SEQ && cnt_q != 4'd0;
    start_o      = load_en_i && hready_i && !err_i && htrans_i == HTRANS_NONSEQ && burst_beats(hburst_i) != 4'd0;
    early_term_o = cnt_q != 4'd0 && (htrans_i == HTRANS_IDLE || htrans_i == HTRANS_NONSEQ);
    // Counter reaching 1 means the final beat's address phase is next, so the grant can move now
    last_beat_o  = seq_ok && cnt_q == 4'd2;
    cnt_d        = err_i ? 4'd0 :
                   start_o ? burst_beats(hburst_i) :
                   (hready_i && early_term_o) ? 4'd0 :
                   seq_ok ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/csi2tx_ahb_arbiter.sv
// csi2tx_ahb_arbiter: two-master AHB arbiter with burst, lock and error-response handling
//   hbusreq1/2, hlock1/2 : per-master bus and lock requests
//   htrans/hburst/hready/hresp : muxed shared-bus transfer and response
//   hgrant1/2 : one-hot grant; hmaster/hmastlock : address-phase owner and lock
module csi2tx_ahb_arbiter
  import csi2tx_ahb_pkg::*;
#(
  parameter int ARB_MODE   = 0,
  parameter int DEF_MASTER = 1
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hbusreq1,
  input  logic       hbusreq2,
  input  logic       hlock1,
  input  logic       hlock2,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  input  logic [1:0] hresp,
  output logic       hgrant1,
  output logic       hgrant2,
  output logic [3:0] hmaster,
  output logic       hmastlock
);
  localparam logic DEF2 = DEF_MASTER == 2;
  arb_state_e state_q, state_d;
  logic gnt2_d, pick2, err, arb_en, own_lock, start, last_beat, early_term;
  csi2tx_ahb_burst_cnt u_cnt (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .htrans_i     (htrans),
    .hburst_i     (hburst),
    .hready_i     (hready),
    .err_i        (err),
    .load_en_i    (state_q == ARB),
    .start_o      (start),
    .last_beat_o  (last_beat),
    .early_term_o (early_term)
  );
  always_comb begin
    err      = hresp != HRESP_OKAY;
    own_lock = hgrant2 ? hlock2 : hlock1;
    // Round-robin tie goes to the master not holding the grant, i.e. not the next hmaster owner
    pick2    = hbusreq2 ? (ARB_MODE == 0 || !hbusreq1 || !hgrant2) : (!hbusreq1 && DEF2);
    arb_en   = hready && (state_q == ARB   ? !start :
                          state_q == BURST ? (last_beat || early_term) : !own_lock);
    gnt2_d   = arb_en ? pick2 : hgrant2;
    // First error cycle has hready low, so it only forces ARB; the decision waits for hready
    state_d  = arb_en ? ((pick2 ? hlock2 : hlock1) ? LOCKED : ARB) :
               err    ? ARB :
               start  ? BURST : state_q;
  end
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state_q   <= ARB;
      hgrant1   <= !DEF2;
      hgrant2   <= DEF2;
      hmaster   <= DEF2 ? MST2_ID : MST1_ID;
      hmastlock <= 1'b0;
    end else begin
      state_q <= state_d;
      hgrant1 <= !gnt2_d;
      hgrant2 <= gnt2_d;
      if (hready) begin
        hmaster   <= hgrant2 ? MST2_ID : MST1_ID;
        hmastlock <= own_lock;
      end
    end
endmodule

// File: tb/tb_csi2tx_ahb_arbiter.sv
// tb_csi2tx_ahb_arbiter: scoreboard bench for fixed-priority and round-robin arbiter instances
module tb_csi2tx_ahb_arbiter;
  import csi2tx_ahb_pkg::*;
  logic hclk = 1'b0, hresetn = 1'b0;
  logic hbusreq1 = 1'b0, hbusreq2 = 1'b0, hlock1 = 1'b0, hlock2 = 1'b0, hready = 1'b1;
  logic [1:0] htrans = HTRANS_IDLE, hresp = HRESP_OKAY;
  logic [2:0] hburst = HBURST_SINGLE;
  logic g1_0, g2_0, lk_0, g1_1, g2_1, lk_1;
  logic [3:0] hm_0, hm_1;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    string      tag;
    int         sel;
    logic [6:0] exp;
  } item_t;
  item_t sb[$];
  item_t mon_it;
  always #5 hclk = ~hclk;
  csi2tx_ahb_arbiter #(.ARB_MODE(0), .DEF_MASTER(1)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hbusreq1(hbusreq1), .hbusreq2(hbusreq2),
    .hlock1(hlock1), .hlock2(hlock2), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hresp(hresp), .hgrant1(g1_0), .hgrant2(g2_0),
    .hmaster(hm_0), .hmastlock(lk_0)
  );
  csi2tx_ahb_arbiter #(.ARB_MODE(1), .DEF_MASTER(1)) u1 (
    .hclk(hclk), .hresetn(hresetn), .hbusreq1(hbusreq1), .hbusreq2(hbusreq2),
    .hlock1(hlock1), .hlock2(hlock2), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hresp(hresp), .hgrant1(g1_1), .hgrant2(g2_1),
    .hmaster(hm_1), .hmastlock(lk_1)
  );
  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] e(input int g, input int m, input bit l);
    return {g == 1, g == 2, m == 1 ? MST1_ID : MST2_ID, l};
  endfunction
  task automatic bus(input logic [1:0] t, input logic [2:0] b, input logic r = 1'b1,
                     input logic [1:0] s = HRESP_OKAY);
    htrans = t;
    hburst = b;
    hready = r;
    hresp  = s;
  endtask
  // sel: 0 = fixed-priority instance, 1 = round-robin instance, 2 = both
  task automatic tick(input string tag, input int sel, input logic [6:0] exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
    @(negedge hclk);
  endtask
  always @(posedge hclk) begin
    #1;
    if (sb.size() != 0) begin
      mon_it = sb.pop_front();
      if (mon_it.sel != 1) check({mon_it.tag, "/fp"}, {g1_0, g2_0, hm_0, lk_0}, mon_it.exp);
      if (mon_it.sel != 0) check({mon_it.tag, "/rr"}, {g1_1, g2_1, hm_1, lk_1}, mon_it.exp);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    check("rst_fp", {g1_0, g2_0, hm_0, lk_0}, e(1, 1, 0));
    check("rst_rr", {g1_1, g2_1, hm_1, lk_1}, e(1, 1, 0));
    @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 10; i++) tick("idle", 2, e(1, 1, 0));
    // fixed priority: master 1 singles, then master 2 requests
    hbusreq1 = 1'b1;
    bus(HTRANS_NONSEQ, HBURST_SINGLE);
    tick("m1_single", 0, e(1, 1, 0));
    tick("m1_single", 0, e(1, 1, 0));
    hbusreq2 = 1'b1;
    tick("req2_grant", 0, e(2, 1, 0));
    tick("req2_owner", 0, e(2, 2, 0));
    hbusreq2 = 1'b0;
    tick("back_grant", 0, e(1, 2, 0));
    tick("back_owner", 0, e(1, 1, 0));
    // INCR8 with BUSY and a wait state; master 2 waiting from beat 1
    bus(HTRANS_NONSEQ, HBURST_INCR8);
    hbusreq2 = 1'b1;
    tick("b8_nonseq", 0, e(1, 1, 0));
    bus(HTRANS_SEQ, HBURST_INCR8);
    tick("b8_beat2", 0, e(1, 1, 0));
    bus(HTRANS_BUSY, HBURST_INCR8);
    tick("b8_busy", 0, e(1, 1, 0));
    bus(HTRANS_SEQ, HBURST_INCR8);
    tick("b8_beat3", 0, e(1, 1, 0));
    bus(HTRANS_SEQ, HBURST_INCR8, 1'b0);
    tick("b8_wait", 0, e(1, 1, 0));
    bus(HTRANS_SEQ, HBURST_INCR8);
    for (int i = 4; i <= 6; i++) tick("b8_mid", 0, e(1, 1, 0));
    tick("b8_beat7", 0, e(2, 1, 0));
    check("b8_cnt_at7", {3'b0, u0.u_cnt.cnt_q}, 7'd1);
    tick("b8_beat8", 0, e(2, 2, 0));
    check("b8_cnt_at8", {3'b0, u0.u_cnt.cnt_q}, 7'd0);
    hbusreq2 = 1'b0;
    bus(HTRANS_IDLE, HBURST_SINGLE);
    tick("b8_release", 0, e(1, 2, 0));
    tick("b8_back", 0, e(1, 1, 0));
    // round-robin: both request continuously
    hresetn = 1'b0;
    hbusreq1 = 1'b1;
    hbusreq2 = 1'b1;
    bus(HTRANS_NONSEQ, HBURST_SINGLE);
    @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 6; i++) tick("rr_alt", 1, (i % 2 == 0) ? e(2, 1, 0) : e(1, 2, 0));
    // master 2 locked over three INCR4 bursts
    hresetn = 1'b0;
    hlock2 = 1'b1;
    bus(HTRANS_IDLE, HBURST_SINGLE);
    @(negedge hclk);
    hresetn = 1'b1;
    tick("lk_grant", 0, e(2, 1, 0));
    for (int b = 0; b < 3; b++) begin
      bus(HTRANS_NONSEQ, HBURST_INCR4);
      tick("lk_nonseq", 0, e(2, 2, 1));
      bus(HTRANS_SEQ, HBURST_INCR4);
      for (int i = 0; i < 3; i++) tick("lk_seq", 0, e(2, 2, 1));
    end
    hlock2 = 1'b0;
    hbusreq2 = 1'b0;
    bus(HTRANS_IDLE, HBURST_SINGLE);
    tick("lk_drop", 0, e(1, 2, 0));
    tick("lk_owner", 0, e(1, 1, 0));
    // INCR16 aborted by ERROR on beat 5
    bus(HTRANS_NONSEQ, HBURST_INCR16);
    tick("err_nonseq", 0, e(1, 1, 0));
    hbusreq2 = 1'b1;
    bus(HTRANS_SEQ, HBURST_INCR16);
    for (int i = 2; i <= 4; i++) tick("err_beat", 0, e(1, 1, 0));
    check("err_cnt_before", {3'b0, u0.u_cnt.cnt_q}, 7'd12);
    bus(HTRANS_SEQ, HBURST_INCR16, 1'b0, HRESP_ERROR);
    tick("err_1st", 0, e(1, 1, 0));
    check("err_cnt_clr", {3'b0, u0.u_cnt.cnt_q}, 7'd0);
    bus(HTRANS_IDLE, HBURST_INCR16, 1'b1, HRESP_ERROR);
    tick("err_2nd", 0, e(2, 1, 0));
    bus(HTRANS_IDLE, HBURST_SINGLE);
    tick("err_owner", 0, e(2, 2, 0));
    // locked master 1 burst interrupted by reset
    hbusreq2 = 1'b0;
    hlock1 = 1'b1;
    tick("l1_grant", 0, e(1, 2, 0));
    bus(HTRANS_NONSEQ, HBURST_INCR8);
    tick("l1_nonseq", 0, e(1, 1, 1));
    bus(HTRANS_SEQ, HBURST_INCR8);
    tick("l1_seq", 0, e(1, 1, 1));
    #2;
    hresetn = 1'b0;
    #1;
    check("rst_mid_fp", {g1_0, g2_0, hm_0, lk_0}, e(1, 1, 0));
    check("rst_mid_rr", {g1_1, g2_1, hm_1, lk_1}, e(1, 1, 0));
    check("rst_mid_cnt", {3'b0, u1.u_cnt.cnt_q}, 7'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    hlock1 = 1'b0;
    hbusreq1 = 1'b0;
    bus(HTRANS_IDLE, HBURST_SINGLE);
    tick("post_rst", 2, e(1, 1, 0));
    tick("post_rst", 2, e(1, 1, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
